// File: rtl/color_mapping_pkg.sv
// Shared constants, requester-index type and one-hot helper for the color_mapping
// shared-multiplier arbiter.
package color_mapping_pkg;

    localparam int A_W       = 37;
    localparam int B_W       = 6;
    localparam int P_W       = A_W + B_W;
    localparam int DEF_N_REQ = 3;
    localparam int DEF_ID_W  = 2;
    localparam int MAX_REQ   = 8;
    localparam int MAX_ID_W  = 3;

    typedef logic [MAX_ID_W-1:0] req_id_t;

    function automatic logic [MAX_REQ-1:0] onehot(input req_id_t id);
        return {{(MAX_REQ-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

// File: rtl/color_mapping_mul_arbiter_if.sv
// Request/response bundle between the color_mapping channel datapaths and the
// shared multiplier arbiter.
interface color_mapping_mul_arbiter_if #(
    parameter int N_REQ = 3
) ();

    logic [N_REQ-1:0]                        req_valid;
    logic [N_REQ-1:0]                        req_ready;
    logic [N_REQ*color_mapping_pkg::A_W-1:0] req_a;
    logic [N_REQ*color_mapping_pkg::B_W-1:0] req_b;
    logic [N_REQ-1:0]                        rsp_valid;
    logic [N_REQ-1:0]                        rsp_ready;
    logic [color_mapping_pkg::P_W-1:0]       rsp_data;
    logic                                    busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/color_mapping_rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after rr_ptr and wraps,
// producing a one-hot grant only while enable is high.
module color_mapping_rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant
);

    logic            found_s;
    logic            hit_s;
    logic [ID_W-1:0] idx_s;

    // first requester at or after rr_ptr+1 (modulo N_REQ) wins
    always_comb begin
        grant   = {N_REQ{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        idx_s   = {ID_W{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            idx_s        = ID_W'((int'(rr_ptr) + k) % N_REQ);
            hit_s        = enable & ~found_s & req[idx_s];
            grant[idx_s] = grant[idx_s] | hit_s;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/color_mapping_mul_arbiter.sv
// Round-robin shared 37x6 multiplier: operand stage, product stage, one-hot
// response routed back to the owning requester.
module color_mapping_mul_arbiter
    import color_mapping_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    color_mapping_mul_arbiter_if.slave  bus
);

    logic             s1_vld_q, s1_vld_d;
    logic [ID_W-1:0]  s1_id_q,  s1_id_d;
    logic [A_W-1:0]   s1_a_q,   s1_a_d;
    logic [B_W-1:0]   s1_b_q,   s1_b_d;
    logic             s2_vld_q, s2_vld_d;
    logic [ID_W-1:0]  s2_id_q,  s2_id_d;
    logic [P_W-1:0]   s2_p_q,   s2_p_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [N_REQ-1:0] own_s;
    logic [N_REQ-1:0] grant_s;
    logic             s2_adv_s;
    logic             s1_adv_s;
    logic             accept_s;
    logic             arb_en_s;
    logic [A_W-1:0]   a_sel_s;
    logic [B_W-1:0]   b_sel_s;
    logic [ID_W-1:0]  gnt_idx_s;

    // pipeline advance conditions; only the owner's rsp_ready matters
    always_comb begin
        own_s    = N_REQ'(onehot(req_id_t'(s2_id_q)));
        s2_adv_s = !s2_vld_q || ((bus.rsp_ready & own_s) != {N_REQ{1'b0}});
        s1_adv_s = !s1_vld_q || s2_adv_s;
        arb_en_s = s1_adv_s && !ap_rst;
    end

    color_mapping_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr_q),
        .enable (arb_en_s),
        .grant  (grant_s)
    );

    // one-hot grant selects the accepted operands and its index
    always_comb begin
        a_sel_s   = {A_W{1'b0}};
        b_sel_s   = {B_W{1'b0}};
        gnt_idx_s = {ID_W{1'b0}};
        accept_s  = |grant_s;
        for (int i = 0; i < N_REQ; i++) begin
            a_sel_s   = a_sel_s | (bus.req_a[i*A_W +: A_W] & {A_W{grant_s[i]}});
            b_sel_s   = b_sel_s | (bus.req_b[i*B_W +: B_W] & {B_W{grant_s[i]}});
            gnt_idx_s = gnt_idx_s | (grant_s[i] ? ID_W'(i) : {ID_W{1'b0}});
        end
    end

    // next-state for both pipeline stages and the round-robin pointer
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_id_d  = s1_id_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        rr_ptr_d = rr_ptr_q;
        s2_vld_d = s2_vld_q;
        s2_id_d  = s2_id_q;
        s2_p_d   = s2_p_q;
        if (accept_s) begin
            s1_vld_d = 1'b1;
            s1_id_d  = gnt_idx_s;
            s1_a_d   = a_sel_s;
            s1_b_d   = b_sel_s;
            rr_ptr_d = gnt_idx_s;
        end else if (s1_adv_s) begin
            s1_vld_d = 1'b0;
        end else begin
            s1_vld_d = s1_vld_q;
        end
        // stage 2 loads only when it can advance, so a held result is never lost
        if (s2_adv_s) begin
            s2_vld_d = s1_vld_q;
            s2_id_d  = s1_id_q;
            s2_p_d   = P_W'(s1_a_q) * P_W'(s1_b_q);
        end else begin
            s2_p_d   = s2_p_q;
        end
    end

    // state registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s1_vld_q <= 1'b0;
            s1_id_q  <= {ID_W{1'b0}};
            s1_a_q   <= {A_W{1'b0}};
            s1_b_q   <= {B_W{1'b0}};
            s2_vld_q <= 1'b0;
            s2_id_q  <= {ID_W{1'b0}};
            s2_p_q   <= {P_W{1'b0}};
            rr_ptr_q <= ID_W'(N_REQ - 1);
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_id_q  <= s1_id_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s2_vld_q <= s2_vld_d;
            s2_id_q  <= s2_id_d;
            s2_p_q   <= s2_p_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.rsp_valid = s2_vld_q ? own_s : {N_REQ{1'b0}};
    assign bus.rsp_data  = s2_p_q;
    assign bus.busy      = s1_vld_q | s2_vld_q;

endmodule

// File: tb/tb_color_mapping_mul_arbiter.sv
// Directed bench for color_mapping_mul_arbiter: a queue-based pipeline model is
// compared every cycle, plus hand-computed literals at key points.
module tb_color_mapping_mul_arbiter;
    import color_mapping_pkg::*;

    localparam int N = 3;

    logic ap_clk;
    logic ap_rst;
    int   n_cmp = 0;
    int   n_err = 0;

    color_mapping_mul_arbiter_if #(.N_REQ(N)) bus ();

    color_mapping_mul_arbiter #(.N_REQ(N), .ID_W(2)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d @%0t", name, got, exp, $time);
        end
    endtask

    // Model: in-flight items in order; an item is visible two cycles after
    // acceptance once it is at the head; at most two items held.
    typedef struct {
        int             id;
        logic [P_W-1:0] p;
        int             t;
    } item_t;

    item_t q[$];
    int    last_g = N - 1;
    int    cyc    = 0;

    always @(negedge ap_clk) begin
        logic           head_vis;
        logic           departing;
        logic           can_acc;
        logic [N-1:0]   exp_rv;
        logic [N-1:0]   exp_rr;
        logic [63:0]    prod;
        int             g;
        int             idx;
        item_t          it;
        if (ap_rst) begin
            q.delete();
            last_g = N - 1;
            cyc    = 0;
        end else begin
            head_vis  = (q.size() > 0) && (cyc >= q[0].t + 2);
            exp_rv    = head_vis ? N'(1 << q[0].id) : '0;
            departing = head_vis && bus.rsp_ready[q[0].id];
            can_acc   = (q.size() < 2) || departing;
            g = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (last_g + k) % N;
                if (g < 0 && bus.req_valid[idx]) g = idx;
            end
            exp_rr = (can_acc && g >= 0) ? N'(1 << g) : '0;
            check("m_req_ready", 64'(bus.req_ready), 64'(exp_rr));
            check("m_rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
            check("m_busy", 64'(bus.busy), 64'(q.size() > 0));
            if (head_vis) check("m_rsp_data", 64'(bus.rsp_data), 64'(q[0].p));
            if (departing) void'(q.pop_front());
            if (can_acc && g >= 0) begin
                prod = 64'(bus.req_a[g*A_W +: A_W]) * 64'(bus.req_b[g*B_W +: B_W]);
                it.id = g;
                it.p  = P_W'(prod);
                it.t  = cyc;
                q.push_back(it);
                last_g = g;
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        bus.req_valid[i]         = v;
        bus.req_a[i*A_W +: A_W]  = a;
        bus.req_b[i*B_W +: B_W]  = b;
    endtask

    initial begin
        ap_rst        = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 3'b111;
        step();
        step();
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
        ap_rst = 1'b0;

        // single request, requester 0
        set_req(0, 1'b1, 37'd1000, 6'd3);
        #1 check("t1_ready", 64'(bus.req_ready), 64'd1);
        step(); set_req(0, 1'b0, 37'd0, 6'd0);
        step();
        check("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("t1_rsp_data",  64'(bus.rsp_data),  64'd3000);

        // maximum operands on requester 1
        set_req(1, 1'b1, 37'h1F_FFFF_FFFF, 6'd63);
        #1 check("t2_ready", 64'(bus.req_ready), 64'd2);
        step(); set_req(1, 1'b0, 37'd0, 6'd0);
        step();
        check("t2_rsp_valid", 64'(bus.rsp_valid), 64'd2);
        check("t2_rsp_data",  64'(bus.rsp_data),  64'd8658654068673);

        // sparse requests with wrap: 2 then 0, then pointer sits at 0
        set_req(2, 1'b1, 37'd21, 6'd5);
        #1 check("t3_ready_2", 64'(bus.req_ready), 64'd4);
        step(); set_req(2, 1'b0, 37'd0, 6'd0); set_req(0, 1'b1, 37'd33, 6'd4);
        #1 check("t3_ready_0", 64'(bus.req_ready), 64'd1);
        step(); set_req(0, 1'b0, 37'd0, 6'd0);
        set_req(0, 1'b1, 37'd1, 6'd1); set_req(1, 1'b1, 37'd2, 6'd1); set_req(2, 1'b1, 37'd3, 6'd1);
        #1 check("t3_ptr_after_wrap", 64'(bus.req_ready), 64'd2);
        step(); set_req(1, 1'b0, 37'd0, 6'd0);
        #1 check("t3_next_2", 64'(bus.req_ready), 64'd4);
        step(); set_req(2, 1'b0, 37'd0, 6'd0);
        step(); set_req(0, 1'b0, 37'd0, 6'd0);
        repeat (3) step();

        // reset with both stages full
        bus.rsp_ready = 3'b110;
        set_req(0, 1'b1, 37'd11, 6'd2);
        step(); set_req(0, 1'b0, 37'd0, 6'd0); set_req(1, 1'b1, 37'd13, 6'd3);
        step(); set_req(1, 1'b0, 37'd0, 6'd0); set_req(2, 1'b1, 37'd17, 6'd1);
        #1;
        check("t4_full_ready", 64'(bus.req_ready), 64'd0);
        check("t4_full_busy",  64'(bus.busy),      64'd1);
        check("t4_full_valid", 64'(bus.rsp_valid), 64'd1);
        #1 ap_rst = 1'b1;
        #1;
        check("t4_rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("t4_rst_busy",  64'(bus.busy),      64'd0);
        check("t4_rst_ready", 64'(bus.req_ready), 64'd0);
        bus.rsp_ready = 3'b111;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 37'(100 + i), 6'(i + 1));
        step();
        step();
        ap_rst = 1'b0;
        #1;
        check("t4_first_grant", 64'(bus.req_ready), 64'd1);
        check("t4_no_stale",    64'(bus.rsp_valid), 64'd0);

        // continuous round robin: accept j goes to j%3 with a=100+j, b=j+1
        for (int k = 0; k < 8; k++) begin
            if (k >= 2) begin
                check("rr_owner", 64'(bus.rsp_valid), 64'(3'b001 << ((k - 2) % 3)));
                check("rr_data",  64'(bus.rsp_data),  64'((100 + k - 2) * (k - 1)));
            end
            step();
            if (k < 6) begin
                if (k + 3 < 6) set_req(k % 3, 1'b1, 37'(100 + k + 3), 6'(k + 4));
                else           set_req(k % 3, 1'b0, 37'd0, 6'd0);
            end
        end

        // backpressure on requester 1 while requester 2 and then 0 request
        bus.rsp_ready = 3'b101;
        set_req(1, 1'b1, 37'd500, 6'd7);
        #1 check("t5_ready_1", 64'(bus.req_ready), 64'd2);
        step(); set_req(1, 1'b0, 37'd0, 6'd0); set_req(2, 1'b1, 37'd900, 6'd11);
        #1 check("t5_ready_2", 64'(bus.req_ready), 64'd4);
        step(); set_req(2, 1'b0, 37'd0, 6'd0); set_req(0, 1'b1, 37'd7, 6'd2);
        for (int h = 0; h < 5; h++) begin
            #1;
            check("t5_hold_ready", 64'(bus.req_ready), 64'd0);
            check("t5_hold_valid", 64'(bus.rsp_valid), 64'd2);
            check("t5_hold_data",  64'(bus.rsp_data),  64'd3500);
            step();
        end
        bus.rsp_ready = 3'b111;
        #1;
        check("t5_release_ready", 64'(bus.req_ready), 64'd1);
        check("t5_release_valid", 64'(bus.rsp_valid), 64'd2);
        step(); set_req(0, 1'b0, 37'd0, 6'd0);
        check("t5_next_valid", 64'(bus.rsp_valid), 64'd4);
        check("t5_next_data",  64'(bus.rsp_data),  64'd9900);
        step();
        check("t5_last_valid", 64'(bus.rsp_valid), 64'd1);
        check("t5_last_data",  64'(bus.rsp_data),  64'd14);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
